// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction-fetch front end.
//   XLEN             : address/data width
//   NOP_INSTR        : instruction presented to decode when nothing is valid
//   RESET_PC_DEFAULT : default first fetch address
//   fetch_entry_t    : one buffered instruction with its PC
package fetch_pkg;
  localparam int XLEN = 32;
  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;
  localparam logic [XLEN-1:0] RESET_PC_DEFAULT = '0;

  typedef struct packed {
    logic [31:0]     instr;
    logic [XLEN-1:0] pc;
  } fetch_entry_t;
endpackage

// File: rtl/fetch_fifo.sv
// Prefetch buffer: synchronous FIFO of fetch_entry_t.
//   clk, rst     : clock, async active-high reset
//   push/pushEntry : write an entry (ignored when full and not popping)
//   pop          : remove head (ignored when empty)
//   flush        : empty the buffer; wins over push and pop
//   count        : current occupancy (0..DEPTH)
//   head         : oldest entry, meaningful only when count != 0
module fetch_fifo
  import fetch_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   push,
  input  fetch_entry_t           pushEntry,
  input  logic                   pop,
  input  logic                   flush,
  output logic [$clog2(DEPTH):0] count,
  output fetch_entry_t           head
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL = (AW+1)'(DEPTH);

  fetch_entry_t  mem [DEPTH];
  logic [AW-1:0] rdPtr, wrPtr;
  logic          doPush, doPop;

  assign doPop  = pop && (count != '0);
  // A full buffer can still accept when the head leaves in the same cycle.
  assign doPush = push && ((count != FULL) || doPop);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rdPtr <= '0;
      wrPtr <= '0;
      count <= '0;
    end else if (flush) begin
      rdPtr <= '0;
      wrPtr <= '0;
      count <= '0;
    end else begin
      if (doPush) wrPtr <= wrPtr + AW'(1);
      if (doPop)  rdPtr <= rdPtr + AW'(1);
      count <= count + (AW+1)'(doPush) - (AW+1)'(doPop);
    end
  end

  // Storage needs no reset: contents are only observed through count.
  always_ff @(posedge clk) begin
    if (doPush && !flush) mem[wrPtr] <= pushEntry;
  end

  assign head = mem[rdPtr];
endmodule

// File: rtl/fetch_prefetch_unit.sv
// Instruction-fetch front end feeding decode.
// Issues sequential word fetches (valid/ready, in-order responses of variable
// latency), buffers returned words with their PC, and hands one instruction
// per cycle to decode. A redirect flushes the buffer, restarts fetch at the
// target and discards every response still owed for the old stream.
//   clk, rst          : clock, async active-high reset
//   imem_req_*        : fetch request channel (addr word-aligned)
//   imem_rsp_*        : in-order response, no backpressure
//   redirect_*        : taken branch/jump target from execute
//   out_valid/ready   : decode handshake
//   out_instr/pc/pc_plus4 : head instruction (NOP when not valid)
module fetch_prefetch_unit
  import fetch_pkg::*;
#(
  parameter int              FIFO_DEPTH      = 4,
  parameter int              MAX_OUTSTANDING = 2,
  parameter logic [XLEN-1:0] RESET_PC        = RESET_PC_DEFAULT
) (
  input  logic            clk,
  input  logic            rst,
  output logic            imem_req_valid,
  input  logic            imem_req_ready,
  output logic [XLEN-1:0] imem_req_addr,
  input  logic            imem_rsp_valid,
  input  logic [31:0]     imem_rsp_data,
  input  logic            redirect_valid,
  input  logic [XLEN-1:0] redirect_pc,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [31:0]     out_instr,
  output logic [XLEN-1:0] out_pc,
  output logic [XLEN-1:0] out_pc_plus4
);
  localparam int CW = $clog2(FIFO_DEPTH) + 1;
  localparam int OW = $clog2(MAX_OUTSTANDING + 1);

  logic [XLEN-1:0] fetchPc, rspPc, redirTarget;
  logic [OW-1:0]   outstanding, dropCnt, rspDec;
  logic [CW-1:0]   fifoCount;
  logic            reqFire, fifoPush, fifoPop;
  fetch_entry_t    pushEntry, head;

  assign redirTarget = redirect_pc & ~XLEN'(3);
  assign rspDec      = OW'(imem_rsp_valid);

  // Each in-flight request holds a buffer slot, so responses can never
  // overflow the FIFO even with decode stalled.
  assign imem_req_valid = !rst && !redirect_valid
                       && (int'(outstanding) < MAX_OUTSTANDING)
                       && (int'(outstanding) + int'(fifoCount) < FIFO_DEPTH);
  assign imem_req_addr  = fetchPc;
  assign reqFire        = imem_req_valid && imem_req_ready;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fetchPc     <= RESET_PC;
      rspPc       <= RESET_PC;
      outstanding <= '0;
      dropCnt     <= '0;
    end else if (redirect_valid) begin
      // Everything still in flight belongs to the old stream; a response
      // arriving this very cycle is already being thrown away.
      fetchPc     <= redirTarget;
      rspPc       <= redirTarget;
      outstanding <= outstanding - rspDec;
      dropCnt     <= outstanding - rspDec;
    end else begin
      if (reqFire) fetchPc <= fetchPc + XLEN'(4);
      if (imem_rsp_valid) begin
        if (dropCnt != '0) dropCnt <= dropCnt - OW'(1);
        else               rspPc   <= rspPc + XLEN'(4);
      end
      outstanding <= outstanding + OW'(reqFire) - rspDec;
    end
  end

  assign fifoPush        = imem_rsp_valid && (dropCnt == '0) && !redirect_valid;
  assign fifoPop         = out_valid && out_ready;
  assign pushEntry.instr = imem_rsp_data;
  assign pushEntry.pc    = rspPc;

  fetch_fifo #(.DEPTH(FIFO_DEPTH)) uFifo (
    .clk      (clk),
    .rst      (rst),
    .push     (fifoPush),
    .pushEntry(pushEntry),
    .pop      (fifoPop),
    .flush    (redirect_valid),
    .count    (fifoCount),
    .head     (head)
  );

  assign out_valid    = (fifoCount != '0);
  assign out_instr    = out_valid ? head.instr : NOP_INSTR;
  assign out_pc       = out_valid ? head.pc : '0;
  assign out_pc_plus4 = out_pc + XLEN'(4);
endmodule
